mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (read-only) and the load/store
//  path (read/write). Arbitrates, registers the winning request, drives the memory port, counts the
//  fixed read latency and returns a registered response to the winner. Sits between PC/fetch,
//  the LSU and the memory macro in the 32-bit RISC-V core. One transaction in flight at a time.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT       1   memory read latency in cycles from m_en to valid m_rdata; must be >=1
//  STARVE_LIMIT  4   consecutive data grants allowed while if_req pending (MEM_ARB_STARVE_GUARD_EN only)
// PORTS
//  clk       in   1         clock, all logic on rising edge
//  reset     in   1         synchronous, active-high reset
//  if_req    in   1         fetch request; held until if_gnt
//  if_addr   in   ADDR_W    fetch address
//  if_gnt    out  1         fetch request accepted this cycle
//  if_rvalid out  1         one-cycle pulse: if_rdata valid
//  if_rdata  out  DATA_W    fetch read data, registered, held until next if_rvalid
//  d_req     in   1         load/store request; held until d_gnt
//  d_we      in   1         1 = store, 0 = load
//  d_be      in   DATA_W/8  store byte enables
//  d_addr    in   ADDR_W    load/store address
//  d_wdata   in   DATA_W    store data
//  d_gnt     out  1         data request accepted this cycle
//  d_rvalid  out  1         one-cycle pulse: load data valid / store complete
//  d_rdata   out  DATA_W    load data, registered, held until next load response
//  m_en      out  1         memory access strobe, one cycle per transaction
//  m_we      out  1         memory write enable (only with m_en)
//  m_be      out  DATA_W/8  memory byte enables
//  m_addr    out  ADDR_W    memory address
//  m_wdata   out  DATA_W    memory write data
//  m_rdata   in   DATA_W    memory read data, valid MEM_LAT cycles after m_en
//  busy      out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs, captured request regs, if_rdata/d_rdata, lat_cnt, starve_cnt = 0.
//  - FSM: IDLE -> ISSUE -> WAIT (loads/fetches) -> RESP -> IDLE; stores go ISSUE -> RESP.
//  - IDLE: gnt combinational = req & winner & (state==IDLE); at most one gnt per cycle. Winner's
//    addr/we/be/wdata and requester ID captured on the grant edge. No req: stay IDLE.
//  - Priority: d_req beats if_req. Grants only in IDLE; req seen in other states waits.
//  - ISSUE (grant+1): m_en=1, m_we/m_be/m_addr/m_wdata from captured regs; m_we=0, m_be=all-ones for reads.
//    m_* outputs are 0 in every state except ISSUE.
//  - WAIT: lat_cnt counts MEM_LAT cycles; m_rdata sampled into winner's rdata reg in the last WAIT cycle.
//  - RESP: winner's rvalid=1 for exactly one cycle. Read: grant-to-rvalid = MEM_LAT+2 cycles.
//    Store: d_rvalid at grant+2, d_rdata unchanged. Non-winner rdata never changes.
//  - Requester drops req before gnt: not served, no side effects. Req changes after gnt: ignored.
//  - Req held high through RESP: re-arbitrated in the following IDLE (period MEM_LAT+3, stores 3).
//  - Reset mid-transaction: abort immediately, no rvalid, no further m_en; requester must re-request.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined: starve_cnt counts data grants issued while if_req=1 and clears on
//    any fetch grant. When starve_cnt==STARVE_LIMIT, the next IDLE arbitration with if_req=1 grants
//    fetch even if d_req=1.
//  Not defined: strict data priority, no starve_cnt; fetch can starve indefinitely.
// STRUCTURE
//  - Package mem_arb_pkg: FSM state encodings, requester IDs (REQ_IF, REQ_D), MEM_LAT counter width function.
//  - Sub-module mem_arb_pick: combinational winner select plus the starve counter (guard compiled in/out there).
//  - Top: FSM, capture regs, latency counter, response regs.
// TESTING (memory model with MEM_LAT=1, m_rdata = ~m_addr)
//  1. reset high 2 cycles mid-traffic -> all outputs 0, busy=0 next cycle, no rvalid.
//  2. if_req, if_addr=0x00000010 at cycle 0 -> if_gnt c0; m_en, m_addr=0x10 c1; if_rvalid, if_rdata=0xFFFFFFEF c3.
//  3. if_req + d_req load 0x100 at c0 -> d_gnt c0, d_rvalid c3 with d_rdata=0xFFFFFEFF; if_gnt c4.
//  4. store d_addr=0x200, d_be=4'b0011, d_wdata=0xDEADBEEF -> c1 m_en=m_we=1, m_be=0011; d_rvalid c2, d_rdata unchanged.
//  5. load granted c0, reset at c2 (WAIT) -> no d_rvalid, no further m_en; new if_req after reset served normally.
//  6. d_req+if_req held, STARVE_LIMIT=4 -> with macro: grants 1-4 data, 5th fetch; without macro: fetch never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, requester IDs and
// the latency counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Counter only has to reach MEM_LAT-1, but keep at least one bit.
    function automatic int unsigned lat_cnt_w(input int unsigned lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for fetch vs. load/store. Data wins by default; the optional
// fetch anti-starvation guard is enabled with MEM_ARB_STARVE_GUARD_EN.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic idle,
    output logic if_gnt,
    output logic d_gnt
);

    req_id_e winner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt_q;
    logic          starved;

    assign starved = if_req && (starve_cnt_q == SW'(STARVE_LIMIT));

    always_comb begin
        winner = d_req ? REQ_D : REQ_IF;
        if (starved) begin
            winner = REQ_IF;
        end
    end

    // Only data grants that overtook a waiting fetch count towards the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (if_gnt) begin
            starve_cnt_q <= '0;
        end else if (d_gnt && if_req && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_q <= starve_cnt_q + SW'(1);
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, reset};

    always_comb begin
        winner = d_req ? REQ_D : REQ_IF;
    end
`endif

    assign if_gnt = idle && if_req && (winner == REQ_IF);
    assign d_gnt  = idle && d_req && (winner == REQ_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one transaction in
// flight. Fetch anti-starvation guard is enabled with MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned LCW  = lat_cnt_w(MEM_LAT);

    state_e            state_q, state_d;
    req_id_e           id_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LCW-1:0]    lat_cnt_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              idle, lat_done;

    // No grant may be issued while reset is asserted, otherwise it would be silently lost.
    assign idle     = (state_q == StIdle) && !reset;
    assign lat_done = (lat_cnt_q == LCW'(MEM_LAT - 1));

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .idle   (idle),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (if_gnt || d_gnt) state_d = StIssue;
            StIssue: state_d = we_q ? StResp : StWait;
            StWait:  if (lat_done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (d_gnt) begin
                id_q    <= REQ_D;
                we_q    <= d_we;
                be_q    <= d_be;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end else if (if_gnt) begin
                id_q    <= REQ_IF;
                we_q    <= 1'b0;
                be_q    <= '0;
                addr_q  <= if_addr;
                wdata_q <= '0;
            end
            if (state_q == StWait) begin
                lat_cnt_q <= lat_done ? '0 : lat_cnt_q + LCW'(1);
                if (lat_done) begin
                    if (id_q == REQ_D) d_rdata_q <= m_rdata;
                    else               if_rdata_q <= m_rdata;
                end
            end
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (state_q == StIssue) begin
            m_en    = 1'b1;
            m_we    = we_q;
            m_be    = we_q ? be_q : '1;
            m_addr  = addr_q;
            m_wdata = wdata_q;
        end
    end

    assign if_rvalid = (state_q == StResp) && (id_q == REQ_IF);
    assign d_rvalid  = (state_q == StResp) && (id_q == REQ_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a MEM_LAT=1 memory returning ~address.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be, m_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_en, m_we, busy;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;

    localparam logic        O  = 1'b0;
    localparam logic        I  = 1'b1;
    localparam logic [3:0]  BZ = 4'h0;
    localparam logic [3:0]  BF = 4'hF;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] EF = 32'hFFFF_FFEF;
    localparam logic [31:0] DF = 32'hFFFF_FFDF;
    localparam logic [31:0] AF = 32'hFFFF_FFAF;
    localparam logic [31:0] LD = 32'hFFFF_FEFF;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .busy      (busy)
    );

    // One-cycle-latency memory: data returned is the inverted address.
    always_ff @(posedge clk) begin
        if (m_en) m_rdata <= ~m_addr;
    end

    typedef struct {
        logic rst, ifr;  logic [31:0] ifa;
        logic dr, dwe;   logic [3:0] dbe; logic [31:0] da, dwd;
        logic eig, edg, eir; logic [31:0] eird;
        logic edr;       logic [31:0] edrd;
        logic emen, emwe; logic [3:0] embe; logic [31:0] ema, emwd;
        logic ebusy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, ifr, input logic [31:0] ifa, input logic dr, dwe,
        input logic [3:0] dbe, input logic [31:0] da, dwd,
        input logic eig, edg, eir, input logic [31:0] eird, input logic edr,
        input logic [31:0] edrd, input logic emen, emwe, input logic [3:0] embe,
        input logic [31:0] ema, emwd, input logic ebusy);
        vec_t v;
        v.rst = rst;  v.ifr = ifr;  v.ifa = ifa;  v.dr = dr;  v.dwe = dwe;
        v.dbe = dbe;  v.da = da;    v.dwd = dwd;
        v.eig = eig;  v.edg = edg;  v.eir = eir;  v.eird = eird;
        v.edr = edr;  v.edrd = edrd; v.emen = emen; v.emwe = emwe;
        v.embe = embe; v.ema = ema; v.emwd = emwd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d.", idx);
        reset = v.rst;  if_req = v.ifr;  if_addr = v.ifa;
        d_req = v.dr;   d_we = v.dwe;    d_be = v.dbe;  d_addr = v.da;  d_wdata = v.dwd;
        @(negedge clk);
        chk({p, "if_gnt"},    32'(if_gnt),    32'(v.eig));
        chk({p, "d_gnt"},     32'(d_gnt),     32'(v.edg));
        chk({p, "if_rvalid"}, 32'(if_rvalid), 32'(v.eir));
        chk({p, "if_rdata"},  if_rdata,       v.eird);
        chk({p, "d_rvalid"},  32'(d_rvalid),  32'(v.edr));
        chk({p, "d_rdata"},   d_rdata,        v.edrd);
        chk({p, "m_en"},      32'(m_en),      32'(v.emen));
        chk({p, "m_we"},      32'(m_we),      32'(v.emwe));
        chk({p, "m_be"},      32'(m_be),      32'(v.embe));
        chk({p, "m_addr"},    m_addr,         v.ema);
        chk({p, "m_wdata"},   m_wdata,        v.emwd);
        chk({p, "busy"},      32'(busy),      32'(v.ebusy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        int          ng, cyc;
        logic [5:0]  seq, exp_seq;
        int          gcyc[6];

        // Fetch, then load beating a fetch, then the delayed fetch, a store and a dropped request.
        //            rst ifr ifa  dr dwe dbe  da    dwd          ig dg ir ird  dr drd men mwe mbe ma  mwd bsy
        tbl[0]  = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, Z,  O, Z, O, O, BZ, Z, Z, O);
        tbl[1]  = mk(O, I, 32'h10, O, O, BZ, Z, Z,   I, O, O, Z,  O, Z, O, O, BZ, Z, Z, O);
        tbl[2]  = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, Z,  O, Z, I, O, BF, 32'h10, Z, I);
        tbl[3]  = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, Z,  O, Z, O, O, BZ, Z, Z, I);
        tbl[4]  = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, I, EF, O, Z, O, O, BZ, Z, Z, I);
        tbl[5]  = mk(O, I, 32'h20, I, O, BZ, 32'h100, Z, O, I, O, EF, O, Z, O, O, BZ, Z, Z, O);
        tbl[6]  = mk(O, I, 32'h20, O, O, BZ, Z, Z,   O, O, O, EF, O, Z, I, O, BF, 32'h100, Z, I);
        tbl[7]  = mk(O, I, 32'h20, O, O, BZ, Z, Z,   O, O, O, EF, O, Z, O, O, BZ, Z, Z, I);
        tbl[8]  = mk(O, I, 32'h20, O, O, BZ, Z, Z,   O, O, O, EF, I, LD, O, O, BZ, Z, Z, I);
        tbl[9]  = mk(O, I, 32'h20, O, O, BZ, Z, Z,   I, O, O, EF, O, LD, O, O, BZ, Z, Z, O);
        tbl[10] = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, EF, O, LD, I, O, BF, 32'h20, Z, I);
        tbl[11] = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, EF, O, LD, O, O, BZ, Z, Z, I);
        tbl[12] = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, I, DF, O, LD, O, O, BZ, Z, Z, I);
        tbl[13] = mk(O, O, Z, I, I, 4'h3, 32'h200, 32'hDEADBEEF,
                     O, I, O, DF, O, LD, O, O, BZ, Z, Z, O);
        tbl[14] = mk(O, I, 32'h40, O, O, BZ, Z, Z,   O, O, O, DF, O, LD,
                     I, I, 4'h3, 32'h200, 32'hDEADBEEF, I);
        tbl[15] = mk(O, I, 32'h40, O, O, BZ, Z, Z,   O, O, O, DF, I, LD, O, O, BZ, Z, Z, I);
        tbl[16] = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, DF, O, LD, O, O, BZ, Z, Z, O);
        tbl[17] = mk(O, O, Z,     O, O, BZ, Z, Z,    O, O, O, DF, O, LD, O, O, BZ, Z, Z, O);

        reset = 1'b1;  if_req = 1'b0;  if_addr = '0;
        d_req = 1'b0;  d_we = 1'b0;    d_be = '0;  d_addr = '0;  d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Load aborted by a two-cycle reset while in WAIT; a later fetch is served normally.
        run_vec(mk(O, O, Z, I, O, BZ, 32'h300, Z, O, I, O, DF, O, LD, O, O, BZ, Z, Z, O), 100);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, O, DF, O, LD, I, O, BF, 32'h300, Z, I), 101);
        run_vec(mk(I, O, Z, O, O, BZ, Z, Z, O, O, O, DF, O, LD, O, O, BZ, Z, Z, I), 102);
        run_vec(mk(I, I, 32'h50, O, O, BZ, Z, Z, O, O, O, Z, O, Z, O, O, BZ, Z, Z, O), 103);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, O, Z, O, Z, O, O, BZ, Z, Z, O), 104);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, O, Z, O, Z, O, O, BZ, Z, Z, O), 105);
        run_vec(mk(O, I, 32'h50, O, O, BZ, Z, Z, I, O, O, Z, O, Z, O, O, BZ, Z, Z, O), 106);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, O, Z, O, Z, I, O, BF, 32'h50, Z, I), 107);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, O, Z, O, Z, O, O, BZ, Z, Z, I), 108);
        run_vec(mk(O, O, Z, O, O, BZ, Z, Z, O, O, I, AF, O, Z, O, O, BZ, Z, Z, I), 109);

        // Both requesters held high: record the order of the first six grants.
        reset = 1'b1;  if_req = 1'b0;  d_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;  if_req = 1'b1;  if_addr = 32'h60;
        d_req = 1'b1;  d_we = 1'b0;    d_addr = 32'h400;
        ng  = 0;
        cyc = 0;
        seq = '0;
        while (ng < 6 && cyc < 80) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                chk($sformatf("starve.single_gnt%0d", ng), 32'(if_gnt & d_gnt), 32'd0);
                seq[ng]  = d_gnt;
                gcyc[ng] = cyc;
                ng++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("starve.grant_count", 32'(ng), 32'd6);
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_seq = 6'b101111;
`else
        exp_seq = 6'b111111;
`endif
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("starve.grant%0d_is_data", i), 32'(seq[i]), 32'(exp_seq[i]));
        end
        if (ng >= 2) chk("starve.load_period", 32'(gcyc[1] - gcyc[0]), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
